full_adder_n: RTL and testbench
===============================

// Module: full_adder_n
// PURPOSE
//   Unsigned N-bit ripple-carry adder with registered outputs: sum = a + b, carry-out on Cout.
//   No carry-in: the LSB stage carry-in is tied to 0.
//   Generic arithmetic leaf for datapaths that need a width-parameterised adder with a
//   one-cycle-registered, glitch-free result.
// PARAMETERS
//   N  default 5  operand/sum width in bits; legal range N >= 1
// PORTS
//   clk    in   1    single clock; all state updates on rising edge
//   rst_n  in   1    asynchronous, active-low reset
//   a      in   N    unsigned operand A
//   b      in   N    unsigned operand B
//   sum    out  N    registered low N bits of a + b
//   Cout   out  1    registered carry-out (bit N of a + b)
// BEHAVIOUR
//   - Interface: one clock (clk); reset rst_n is asynchronous and active-low.
//   - Reset:
//     - rst_n = 0 forces sum = 0 and Cout = 0 immediately, independent of clk.
//     - Outputs hold 0 while rst_n is low.
//     - Release is sampled at the next rising clk edge.
//   - Arithmetic:
//     - Combinational ripple chain: c[0] = 0; s[i] = a[i]^b[i]^c[i];
//       c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]).
//     - Next-state {Cout, sum} = {c[N], s[N-1:0]}, i.e. the (N+1)-bit zero-extended a + b.
//   - Latency: exactly 1 cycle.
//     - Operands present before rising edge k appear on sum/Cout after edge k.
//     - A new operand pair is accepted every cycle; no handshake, no stall, no valid signal.
//   - Overflow / wrap-around:
//     - sum wraps modulo 2^N.
//     - Cout = 1 iff a + b >= 2^N.
//     - No saturation, no sign handling.
//   - Boundaries:
//     - a = b = 0 gives 0/0.
//     - a = b = 2^N-1 gives sum = 2^N-2, Cout = 1.
//     - a = 2^N-1, b = 1 gives full carry propagation through all N stages: sum = 0, Cout = 1.
//   - Reset mid-operation: any pending result is discarded. The first post-reset edge
//     registers the operands present at that edge.
//   - X on a or b propagates to outputs; no X-masking.
//   - No state other than the N+1 output flops. No FSM.
// STRUCTURE
//   - Sub-module full_adder (1-bit; ports a, b, cin, sum, cout), instantiated N times in a
//     generate loop to form the carry chain.
//   - Top level holds the carry vector c[N:0] and the output register block.
//   - No shared package required; the adder is purely parameter-driven.
//   - If a package exists for the datapath, it may host a localparam ADD_W default only.
// TESTING  (N = 5; check outputs one clk after applying operands)
//   1. rst_n=0 with a=5'b10101, b=5'b01010 -> sum=0, Cout=0 asynchronously, held until release.
//   2. a=5'b00111 (7), b=5'b01011 (11) -> sum=5'b10010 (18), Cout=0.
//   3. a=5'b01111 (15), b=5'b11011 (27) -> sum=5'b01010 (10), Cout=1 (total 42).
//   4. a=5'b11111, b=5'b00001 -> sum=0, Cout=1 (full ripple).
//      Then a=b=5'b11111 -> sum=5'b11110, Cout=1.
//   5. Back-to-back: change operands every cycle -> each result appears exactly 1 cycle later,
//      no bubbles.
//   6. Assert rst_n low between edges while a result is pending -> outputs drop to 0 at once.
//      After release, the next edge registers the current operands.
//      Randomised pass (>=1000 pairs) vs. a + b reference model.

Source files
------------

// File: rtl/full_adder_n_pkg.sv
// Shared datapath constants for the width-parameterised ripple adder.
package full_adder_n_pkg;
   localparam int ADD_W = 5;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the top-level adder chains N of these through cin/cout.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   logic p;

   assign p    = a ^ b;
   assign sum  = p ^ cin;
   assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/full_adder_n.sv
// N-bit ripple-carry adder with carry-in tied low and a one-cycle registered {Cout, sum}.
module full_adder_n
   import full_adder_n_pkg::*;
#(
   parameter int N = ADD_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] sum,
   output logic         Cout
);
   logic [N:0]   c;
   logic [N-1:0] s;
   logic [N-1:0] sum_d, sum_q;
   logic         cout_d, cout_q;

   assign c[0] = 1'b0;

   for (genvar i = 0; i < N; i++) begin : g_chain
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .sum  (s[i]),
         .cout (c[i+1])
      );
   end

   always_comb begin
      sum_d  = s;
      cout_d = c[N];
   end

   // Registering the ripple result hides its settling glitches from downstream logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign Cout = cout_q;
endmodule

// File: tb/tb_full_adder_n.sv
// Self-checking bench for full_adder_n: directed boundary cases plus a randomised run vs. a + b.
module tb_full_adder_n;
   localparam int N = 5;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] a, b, sum;
   logic         Cout;

   int n_tests = 0;
   int n_fail  = 0;
   logic [N:0] exp_q;
   logic       chk_en = 1'b0;

   always #5 clk = ~clk;

   full_adder_n #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .sum   (sum),
      .Cout  (Cout)
   );

   // Reference: last accepted pair summed as plain (N+1)-bit integers; cleared by reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) exp_q <= '0;
      else        exp_q <= {1'b0, a} + {1'b0, b};
   end

   task automatic check(input string name, input logic [N:0] act, input logic [N:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got {Cout,sum}=%b, expected %b", name, act, expv);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) check("model", {Cout, sum}, exp_q);
   end

   task automatic apply(input string name, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic [N:0] expv);
      @(negedge clk);
      a = av;
      b = bv;
      @(posedge clk);
      #1;
      check(name, {Cout, sum}, expv);
      check({name, "_ref"}, exp_q, expv);
   endtask

   initial begin
      rst_n = 1'b0;
      a     = 5'b10101;
      b     = 5'b01010;
      #3;
      check("rst_async", {Cout, sum}, 6'd0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold", {Cout, sum}, 6'd0);

      @(negedge clk);
      rst_n = 1'b1;
      a     = 5'b00111;
      b     = 5'b01011;
      @(posedge clk);
      #1;
      check("7+11", {Cout, sum}, 6'b010010);
      check("7+11_ref", exp_q, 6'b010010);
      chk_en = 1'b1;

      apply("15+27", 5'b01111, 5'b11011, 6'b101010);
      apply("31+1", 5'b11111, 5'b00001, 6'b100000);
      apply("31+31", 5'b11111, 5'b11111, 6'b111110);
      apply("0+0", 5'd0, 5'd0, 6'd0);

      // Consecutive pairs, one per cycle, no idle cycles between them.
      apply("b2b_1+2", 5'd1, 5'd2, 6'd3);
      apply("b2b_16+16", 5'd16, 5'd16, 6'd32);
      apply("b2b_5+6", 5'd5, 5'd6, 6'd11);
      apply("b2b_30+3", 5'd30, 5'd3, 6'd33);

      @(negedge clk);
      a = 5'd9;
      b = 5'd4;
      @(posedge clk);
      #1;
      check("pre_midrst", {Cout, sum}, 6'd13);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_async", {Cout, sum}, 6'd0);
      @(negedge clk);
      a     = 5'd20;
      b     = 5'd30;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_20+30", {Cout, sum}, 6'd50);

      repeat (1200) begin
         @(negedge clk);
         a = N'($urandom());
         b = N'($urandom());
      end
      @(posedge clk);
      @(negedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
